// File: rtl/predictor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : predictor_ctrl
// Description : 2-bit saturating branch predictor table with a queued,
//               starvation-bounded update path sharing a single table port.
// Revision    : 1.0 - initial release
// ============================================================================
module predictor_ctrl #(
    parameter int IDX_W      = 4,
    parameter int QDEPTH     = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lu_valid,
    input  logic [IDX_W-1:0] lu_idx,
    output logic             lu_ready,
    output logic             pred_valid,
    output logic             pred,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             busy
);

    localparam int C_DEPTH = 2 ** IDX_W;
    localparam int C_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int C_CNT_W = $clog2(QDEPTH + 1);
    localparam int C_ST_W  = $clog2(STARVE_LIM + 1);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_init_idx;
    logic [1:0]          r_tbl [C_DEPTH];

    logic [IDX_W-1:0]    r_q_idx [QDEPTH];
    logic                r_q_tkn [QDEPTH];
    logic [C_PTR_W-1:0]  r_wptr;
    logic [C_PTR_W-1:0]  r_rptr;
    logic [C_CNT_W-1:0]  r_count;
    logic [C_ST_W-1:0]   r_starve;
    logic                r_pred_valid;
    logic                r_pred;

    logic                w_run;
    logic                w_empty;
    logic                w_full;
    logic                w_force;
    logic                w_drain;
    logic                w_enq;
    logic                w_lu_acc;
    logic [IDX_W-1:0]    w_head_idx;
    logic [1:0]          w_head_cnt;
    logic [1:0]          w_head_new;
    logic                w_we;
    logic [IDX_W-1:0]    w_waddr;
    logic [1:0]          w_wdata;

    // Arbitration between lookup, drain and init for the single table port
    always_comb begin
        w_run      = (r_state == S_RUN);
        w_empty    = (r_count == '0);
        w_full     = (r_count == C_CNT_W'(QDEPTH));
        w_force    = w_full || (r_starve == C_ST_W'(STARVE_LIM));
        lu_ready   = w_run && !w_force;
        upd_ready  = w_run && !w_full;
        busy       = (r_state == S_INIT);
        w_lu_acc   = lu_valid && lu_ready;
        w_enq      = upd_valid && upd_ready;
        // A lookup only wins when it is valid and nothing forces a drain
        w_drain    = w_run && !w_empty && (!lu_valid || w_force);
        w_head_idx = r_q_idx[r_rptr];
        w_head_cnt = r_tbl[w_head_idx];
        w_head_new = w_head_cnt;
        if (r_q_tkn[r_rptr]) begin
            if (w_head_cnt != 2'd3) w_head_new = w_head_cnt + 2'd1;
        end else begin
            if (w_head_cnt != 2'd0) w_head_new = w_head_cnt - 2'd1;
        end
        w_we    = busy || w_drain;
        w_waddr = busy ? r_init_idx : w_head_idx;
        w_wdata = busy ? 2'd3 : w_head_new;
    end

    // Next-state logic: INIT walks every entry once, then RUN forever
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_INIT && r_init_idx == IDX_W'(C_DEPTH - 1)) begin
            w_state_nxt = S_RUN;
        end
    end

    // State register and init walker
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_init_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) r_init_idx <= r_init_idx + 1'b1;
        end
    end

    // Counter table write port; reset suppresses any in-flight drain write
    always_ff @(posedge clk) begin
        if (!rst && w_we) begin
            r_tbl[w_waddr] <= w_wdata;
        end
    end

    // Update queue storage; entries carry no reset, occupancy guards them
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_idx[r_wptr] <= upd_idx;
            r_q_tkn[r_wptr] <= upd_taken;
        end
    end

    // Queue pointers, occupancy and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= (r_wptr == C_PTR_W'(QDEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_drain) begin
                r_rptr <= (r_rptr == C_PTR_W'(QDEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            if (w_enq && !w_drain) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq && w_drain) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drain || w_empty) begin
                r_starve <= '0;
            end else if (r_starve != C_ST_W'(STARVE_LIM)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    // Prediction result: one-cycle valid pulse, direction held between lookups
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred       <= 1'b0;
        end else begin
            r_pred_valid <= w_lu_acc;
            if (w_lu_acc) r_pred <= r_tbl[lu_idx][1];
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred       = r_pred;

endmodule
`default_nettype wire

// File: doc/predictor_ctrl.md
PREDICTOR_CTRL -- requirements
Module: predictor_ctrl

Interface
REQ-001 Parameters SHALL be:
- IDX_W, 4, table index width; table holds 2**IDX_W 2-bit counters.
- QDEPTH, 4, update-queue depth in entries.
- STARVE_LIM, 4, maximum consecutive cycles a non-empty queue waits before a forced drain.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- lu_valid  in  1  lookup request.
- lu_idx  in  IDX_W  lookup table index.
- lu_ready  out  1  lookup can be accepted this cycle.
- pred_valid  out  1  prediction result valid.
- pred  out  1  predicted direction (1 = taken).
- upd_valid  in  1  resolved-branch update request.
- upd_idx  in  IDX_W  update table index.
- upd_taken  in  1  resolved outcome.
- upd_ready  out  1  update can be accepted this cycle.
- busy  out  1  table initialisation in progress.

Function
REQ-003 The block SHALL hold 2**IDX_W counters, encoded 3 = strong taken, 2 = weak taken, 1 = weak not-taken, 0 = strong not-taken.
REQ-004 The table SHALL perform at most one access per cycle: a lookup read, a drain read-modify-write, or an init write.
REQ-005 The FSM SHALL have two states, INIT and RUN; reset SHALL enter INIT.
REQ-006 In INIT, the block SHALL write 3 to entry k on the k-th cycle after reset, for k = 0 .. 2**IDX_W-1, then enter RUN.
- INIT therefore lasts 2**IDX_W cycles.
- busy = 1 throughout INIT; lu_ready = 0 and upd_ready = 0 throughout INIT.
REQ-007 A lookup SHALL be accepted when lu_valid & lu_ready.
- On the next cycle, pred_valid = 1 for exactly one cycle and pred = bit 1 of entry lu_idx as held in the accept cycle.
- Otherwise pred_valid = 0 and pred holds its last value.
REQ-008 An update SHALL be accepted into the FIFO queue when upd_valid & upd_ready, with upd_ready = (state == RUN) & !full.
REQ-009 A drain SHALL pop the queue head and write the new counter value, in the same cycle:
- outcome taken: min(cnt+1, 3).
- outcome not-taken: max(cnt-1, 0).
REQ-010 The force condition SHALL be: queue full, or starve_cnt == STARVE_LIM.
- lu_ready = (state == RUN) & !force.
REQ-011 A drain SHALL occur when the queue is non-empty and either (not lu_valid) or force holds.
- Otherwise an accepted lookup uses the table.
REQ-012 starve_cnt SHALL increment each cycle the queue is non-empty and no drain occurs.
- It SHALL clear on a drain or when the queue is empty.
- It SHALL saturate at STARVE_LIM.
REQ-013 Enqueue and dequeue in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-014 An entry enqueued in cycle t SHALL be drainable no earlier than cycle t+1.
REQ-015 Lookups SHALL NOT be forwarded from the queue.
- A lookup reads table contents only, even when a pending update targets the same index.
REQ-016 Queue pointers SHALL wrap modulo QDEPTH; a full/empty distinction SHALL be kept by an occupancy count of width clog2(QDEPTH+1).
REQ-017 Updates SHALL drain in arrival order.
- Repeated updates to one index SHALL each apply, with saturation.

Reset
REQ-018 On rst = 1 at a clock edge, the block SHALL set:
- state = INIT, init index = 0, queue empty, starve_cnt = 0.
- pred_valid = 0, pred = 0, busy = 1, lu_ready = 0, upd_ready = 0.
REQ-019 Reset during RUN SHALL discard all queued updates and any pending pred_valid, then re-run the full INIT sequence.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- V1: rst for 1 cycle, then release -> busy = 1 for 16 cycles, then 0; lookup of every index -> pred = 1 one cycle after each accept.
- V2: after init, 3 not-taken updates to idx 5 with lu_valid = 0, then lookup idx 5 -> counter 0, pred = 0; then 2 taken updates and a lookup -> counter 2, pred = 1.
- V3: lu_valid held high every cycle, one update to idx 2 enqueued -> the update drains on the 5th cycle after enqueue (STARVE_LIM = 4); lu_ready = 0 exactly that cycle.
- V4: lu_valid high, 4 updates enqueued back-to-back -> upd_ready = 0 when full, lu_ready = 0 while force holds; queue empties in arrival order; no update lost.
- V5: update(idx 7, not-taken) accepted in the same cycle as lookup idx 7 -> pred reflects the pre-update value 3 (pred = 1).
- V6: rst asserted with 3 queued updates -> after re-init, all counters = 3 and no queued update applies.
